// File: rtl/flush_fifo_struct_if.sv
// Handshake bundle between a producer, the flushable FIFO and its consumer.
// The slave side is the FIFO itself; the master side is the environment around it.
interface flush_fifo_struct_if #(
    parameter type T     = logic,
    parameter int  DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          valid_in;
    logic          ready_in;
    T              data_in;
    logic          valid_out;
    logic          ready_out;
    T              data_out;
    logic [CW-1:0] count;

    modport master (
        output valid_in,
        output data_in,
        output ready_out,
        input  ready_in,
        input  valid_out,
        input  data_out,
        input  count
    );

    modport slave (
        input  valid_in,
        input  data_in,
        input  ready_out,
        output ready_in,
        output valid_out,
        output data_out,
        output count
    );
endinterface

// File: rtl/flush_fifo_struct.sv
// DEPTH-entry valid/ready FIFO with a flop-driven ready_in and a one-cycle flush.
// Only pointers and occupancy are cleared; the payload array keeps stale contents.
module flush_fifo_struct #(
    parameter type T     = logic,
    parameter int  DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    flush_fifo_struct_if.slave bus
);
    localparam int            PW       = $clog2(DEPTH);
    localparam int            CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          push, pop, not_empty;

    // ready_in is !full_q, so acceptance never depends on the consumer side.
    assign not_empty = (count_q != '0);
    assign push      = bus.valid_in && !full_q;
    assign pop       = not_empty && bus.ready_out;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        full_d = (count_d == FULL_CNT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    // A beat presented during reset or flush is dropped, so it must not land in storage.
    always_ff @(posedge clk) begin
        if (!reset && !flush && push) begin
            mem[wr_ptr_q] <= bus.data_in;
        end
    end

    assign bus.ready_in  = !full_q;
    assign bus.valid_out = not_empty;
    assign bus.data_out  = not_empty ? mem[rd_ptr_q] : T'(0);
    assign bus.count     = count_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) begin
            assert (count_q <= FULL_CNT);
            assert (full_q == (count_q == FULL_CNT));
            assert (!(push && full_q));
            assert (!(pop && !not_empty));
        end
    end
`endif
endmodule

// File: tb/tb_flush_fifo_struct.sv
// Directed bench for the flushable FIFO: stimulus pushes expected beats into a
// scoreboard queue, and a negedge monitor pops and compares every transfer out.
module tb_flush_fifo_struct;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    logic flush;

    flush_fifo_struct_if #(.T(logic [31:0]), .DEPTH(DEPTH)) bus ();

    flush_fifo_struct #(.T(logic [31:0]), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          mcount = 0;
    bit          mon_en = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] exp_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle where the consumer takes a beat, compare against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!reset && !flush && bus.valid_out && bus.ready_out) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got %h, expected no output", bus.data_out);
                end else begin
                    chk("data_out", bus.data_out, exp_q.pop_front());
                end
                got_q.push_back(bus.data_out);
            end
            if (!bus.valid_out) begin
                chk("idle_data", bus.data_out, 32'h0);
            end
        end
    end

    // One clock of stimulus; status outputs are compared against the occupancy model.
    task automatic step(input bit vin, input logic [31:0] din, input bit rout,
                        input bit fl, input bit rs);
        bit acc;
        bit dq;
        bus.valid_in  = vin;
        bus.data_in   = din;
        bus.ready_out = rout;
        flush         = fl;
        reset         = rs;
        @(negedge clk);
        chk("count", 32'(bus.count), 32'(mcount));
        chk("ready_in", 32'(bus.ready_in), (mcount < DEPTH) ? 32'd1 : 32'd0);
        chk("valid_out", 32'(bus.valid_out), (mcount != 0) ? 32'd1 : 32'd0);
        acc = vin && (mcount < DEPTH);
        dq  = rout && (mcount > 0);
        if (rs || fl) begin
            mcount = 0;
            exp_q.delete();
        end else begin
            if (acc) exp_q.push_back(din);
            mcount = mcount + int'(acc) - int'(dq);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string name);
        chk({name, "_len"}, 32'(got_q.size()), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < got_q.size(); i++) begin
            chk(name, got_q[i], exp_log[i]);
        end
        got_q.delete();
        exp_log.delete();
    endtask

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        bus.valid_in  = 1'b0;
        bus.data_in   = 32'h0;
        bus.ready_out = 1'b0;
        @(posedge clk);
        #1;
        mcount = 0;
        mon_en = 1'b1;

        // Reset held for two cycles
        step(0, 32'h0, 0, 0, 1);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
        chk("rst_ready_in", 32'(bus.ready_in), 32'd1);
        chk("rst_data_out", bus.data_out, 32'h0);

        // Fill to full with the consumer stalled
        for (int i = 0; i < 4; i++) begin
            step(1, 32'(32'hA0 + i), 0, 0, 0);
            chk("fill_count", 32'(bus.count), 32'(i + 1));
        end
        chk("full_ready_in", 32'(bus.ready_in), 32'd0);
        chk("full_head", bus.data_out, 32'hA0);
        step(1, 32'hA4, 0, 0, 0);
        chk("full_hold_count", 32'(bus.count), 32'd4);

        // One pop frees a slot; ready_in returns the following cycle
        step(1, 32'hA4, 1, 0, 0);
        chk("freed_count", 32'(bus.count), 32'd3);
        chk("freed_ready_in", 32'(bus.ready_in), 32'd1);
        step(1, 32'hA4, 0, 0, 0);
        chk("refill_count", 32'(bus.count), 32'd4);
        for (int i = 0; i < 4; i++) step(0, 32'h0, 1, 0, 0);
        chk("drained_count", 32'(bus.count), 32'd0);
        for (int i = 0; i < 5; i++) exp_log.push_back(32'(32'hA0 + i));
        check_log("drain_order");

        // Streaming at occupancy 1 across several pointer wraps
        step(1, 32'd1, 0, 0, 0);
        for (int k = 2; k <= 20; k++) begin
            step(1, 32'(k), 1, 0, 0);
            chk("stream_count", 32'(bus.count), 32'd1);
        end
        step(0, 32'h0, 1, 0, 0);
        for (int k = 1; k <= 20; k++) exp_log.push_back(32'(k));
        check_log("stream_order");

        // Flush with a concurrent push drops everything including that beat
        step(1, 32'hB0, 0, 0, 0);
        step(1, 32'hB1, 0, 0, 0);
        step(1, 32'hB2, 0, 0, 0);
        step(1, 32'h55, 0, 1, 0);
        chk("flush_count", 32'(bus.count), 32'd0);
        chk("flush_valid_out", 32'(bus.valid_out), 32'd0);
        chk("flush_ready_in", 32'(bus.ready_in), 32'd1);
        step(1, 32'h66, 0, 0, 0);
        chk("post_flush_head", bus.data_out, 32'h66);
        chk("post_flush_count", 32'(bus.count), 32'd1);
        step(0, 32'h0, 1, 0, 0);
        exp_log.push_back(32'h66);
        check_log("flush_order");

        // Reset mid-burst with simultaneous push and pop
        step(1, 32'hC0, 0, 0, 0);
        step(1, 32'hC1, 0, 0, 0);
        step(1, 32'hC2, 1, 0, 1);
        chk("rst2_count", 32'(bus.count), 32'd0);
        chk("rst2_valid_out", 32'(bus.valid_out), 32'd0);
        chk("rst2_ready_in", 32'(bus.ready_in), 32'd1);
        chk("rst2_data_out", bus.data_out, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 32'h0, 1, 0, 0);
        check_log("stale_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
